// File: rtl/operand_stim_gen.sv
// operand_stim_gen: LFSR-driven A/B/C vector source with valid/ready handshake and run control.
// Ports:
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   start, cfg_num  : start a run of cfg_num vectors (sampled only when idle)
//   abort           : end the current run on the next edge
//   A, B, C, valid  : vector out (A=lfsr[15:8], B=lfsr[7:0], C=parity), zero when not valid
//   ready           : consumer accepts when valid && ready
//   busy, done      : run in progress, one-cycle end-of-run pulse
//   vec_idx         : vectors accepted so far in the current run
module operand_stim_gen #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = 16'hB400,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_num,
  input  logic             abort,
  output logic [7:0]       A,
  output logic [7:0]       B,
  output logic             C,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_idx
);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'h0001 : SEED;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [15:0] lfsr;
  logic [CNT_W-1:0] rem;
  logic hs, go;
  assign go = (state == IDLE) && start;
  assign hs = valid && ready;
  assign valid = state == RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  // outputs come straight from the registered lfsr, so they hold while stalled
  assign A = valid ? lfsr[15:8] : '0;
  assign B = valid ? lfsr[7:0] : '0;
  assign C = valid ? ^lfsr : 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (go) state_nxt = (cfg_num != '0) ? RUN : DONE;
    else if (state == RUN) state_nxt = (abort || (hs && rem == CNT_W'(1))) ? DONE : RUN;
    else if (state == DONE) state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lfsr <= SEED_EFF;
      rem <= '0;
      vec_idx <= '0;
    end else if (go) begin
      lfsr <= SEED_EFF;
      rem <= cfg_num;
      vec_idx <= '0;
    end else if (hs) begin
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
      rem <= rem - CNT_W'(1);
      vec_idx <= vec_idx + CNT_W'(1);
    end
endmodule

// File: tb/tb_operand_stim_gen.sv
// tb_operand_stim_gen: randomized and directed check of operand_stim_gen against a run-level model.
module tb_operand_stim_gen;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, ready = 1'b0;
  logic [7:0] cfg_num = '0;
  logic [7:0] A, B, vec_idx;
  logic C, valid, busy, done;
  int total = 0, bad = 0;
  logic [15:0] stream [256];
  bit m_run, m_done;
  int m_idx, m_rem;
  always #5 clk = ~clk;
  operand_stim_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_num(cfg_num), .abort(abort),
    .A(A), .B(B), .C(C), .valid(valid), .ready(ready), .busy(busy), .done(done),
    .vec_idx(vec_idx)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all(input string tag);
    logic [15:0] v;
    v = stream[m_idx];
    chk({tag, ".valid"}, 32'(valid), 32'(m_run));
    chk({tag, ".busy"}, 32'(busy), 32'(m_run));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".idx"}, 32'(vec_idx), 32'(m_idx));
    chk({tag, ".A"}, 32'(A), m_run ? 32'(v[15:8]) : 32'h0);
    chk({tag, ".B"}, 32'(B), m_run ? 32'(v[7:0]) : 32'h0);
    chk({tag, ".C"}, 32'(C), m_run ? 32'(^v) : 32'h0);
  endtask
  task automatic model_reset();
    m_run = 0;
    m_done = 0;
    m_idx = 0;
    m_rem = 0;
  endtask
  task automatic tick(input string tag);
    bit hs;
    hs = m_run && ready;
    if (m_done) m_done = 0;
    else if (!m_run) begin
      if (start) begin
        m_idx = 0;
        m_rem = int'(cfg_num);
        if (cfg_num == 0) m_done = 1;
        else m_run = 1;
      end
    end else begin
      if (hs) begin
        m_idx++;
        m_rem--;
      end
      if (abort || m_rem == 0) begin
        m_run = 0;
        m_done = 1;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask
  initial begin
    stream[0] = 16'hACE1;
    for (int k = 1; k < 256; k++)
      stream[k] = stream[k-1][0] ? ((stream[k-1] >> 1) ^ 16'hB400) : (stream[k-1] >> 1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    ready = 1'b1;
    cfg_num = 8'd2;
    start = 1'b1;
    tick("t1");
    start = 1'b0;
    chk("t1.v0A", 32'(A), 32'hAC);
    chk("t1.v0B", 32'(B), 32'hE1);
    chk("t1.v0C", 32'(C), 32'h0);
    tick("t1");
    chk("t1.v1A", 32'(A), 32'hE2);
    chk("t1.v1B", 32'(B), 32'h70);
    chk("t1.v1C", 32'(C), 32'h1);
    tick("t1");
    chk("t1.done", 32'(done), 32'h1);
    chk("t1.fidx", 32'(vec_idx), 32'h2);
    tick("t1");
    ready = 1'b0;
    cfg_num = 8'd3;
    start = 1'b1;
    tick("bp");
    start = 1'b0;
    repeat (4) tick("bp");
    chk("bp.holdA", 32'(A), 32'hAC);
    ready = 1'b1;
    repeat (4) tick("bp");
    cfg_num = 8'd0;
    start = 1'b1;
    tick("zero");
    start = 1'b0;
    chk("zero.done", 32'(done), 32'h1);
    tick("zero");
    cfg_num = 8'd10;
    start = 1'b1;
    tick("abort");
    start = 1'b0;
    tick("abort");
    abort = 1'b1;
    tick("abort");
    abort = 1'b0;
    chk("abort.idx", 32'(vec_idx), 32'h2);
    tick("abort");
    cfg_num = 8'd1;
    start = 1'b1;
    tick("replay");
    start = 1'b0;
    chk("replay.A", 32'(A), 32'hAC);
    repeat (2) tick("replay");
    cfg_num = 8'd4;
    start = 1'b1;
    tick("restart");
    start = 1'b0;
    tick("restart");
    cfg_num = 8'd9;
    start = 1'b1;
    tick("restart");
    start = 1'b0;
    repeat (5) tick("restart");
    cfg_num = 8'd5;
    start = 1'b1;
    tick("arst");
    start = 1'b0;
    tick("arst");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cfg_num = 8'd1;
    start = 1'b1;
    tick("post");
    start = 1'b0;
    chk("post.A", 32'(A), 32'hAC);
    chk("post.B", 32'(B), 32'hE1);
    repeat (2) tick("post");
    cfg_num = 8'd255;
    start = 1'b1;
    tick("max");
    start = 1'b0;
    repeat (256) tick("max");
    for (int i = 0; i < 400; i++) begin
      ready = $urandom_range(0, 3) != 0;
      abort = $urandom_range(0, 40) == 0;
      start = $urandom_range(0, 5) == 0;
      cfg_num = 8'($urandom_range(0, 15));
      tick("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
